// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, one-word-per-line instruction cache in front of MemCtrl's IC port.
// Build option ICACHE_EN: when defined the tag/data arrays exist; otherwise every fetch goes to MemCtrl.
module inst_cache #(
  parameter  int INDEX_WIDTH = 8,
  localparam int TAG_WIDTH   = 32 - INDEX_WIDTH - 2,
  localparam int LINES       = 1 << INDEX_WIDTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_req_in,
  input  logic [31:0] pc_in,
  output logic [31:0] inst_out,
  output logic        rdy_inst_out,
  output logic        rdy_inst_mc_out,
  output logic [31:0] inst_addr_mc_out,
  input  logic [31:0] inst_mc_in,
  input  logic        rdy_inst_mc_in,
  input  logic        refresh_rob_cdb_in
);

  typedef enum logic {IDLE, MISS} state_t;

  state_t      state, state_n;
  logic        rdy_inst_n, mc_req_n, fill;
  logic [31:0] inst_n, addr_n;
  logic        hit;
  logic [31:0] hit_data;

`ifdef ICACHE_EN
  logic [31:0]            data_mem [LINES];
  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]       valid;
  logic [INDEX_WIDTH-1:0] pc_idx, fill_idx;
  logic                   unused_pc_lo;

  assign pc_idx       = pc_in[INDEX_WIDTH+1:2];
  // the pending miss address register doubles as the latched pc for the fill
  assign fill_idx     = inst_addr_mc_out[INDEX_WIDTH+1:2];
  assign hit          = valid[pc_idx] && (tag_mem[pc_idx] == pc_in[31:INDEX_WIDTH+2]);
  assign hit_data     = data_mem[pc_idx];
  assign unused_pc_lo = ^pc_in[1:0];

  always_ff @(posedge clk_in) begin
    if (rst_in)              valid <= '0;
    else if (rdy_in && fill) valid[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill) begin
      data_mem[fill_idx] <= inst_mc_in;
      tag_mem[fill_idx]  <= inst_addr_mc_out[31:INDEX_WIDTH+2];
    end
  end
`else
  logic unused_nocache;

  assign hit            = 1'b0;
  assign hit_data       = '0;
  assign unused_nocache = fill | (^pc_in[1:0]);
`endif

  always_comb begin
    state_n    = state;
    rdy_inst_n = 1'b0;
    inst_n     = inst_out;
    mc_req_n   = rdy_inst_mc_out;
    addr_n     = inst_addr_mc_out;
    fill       = 1'b0;
    if (refresh_rob_cdb_in) begin
      // flush drops the miss; a response pulse in this cycle is discarded
      state_n  = IDLE;
      mc_req_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // rdy_inst_out high means the fetcher still holds the request just served
          if (fetch_req_in && !rdy_inst_out) begin
            if (hit) begin
              rdy_inst_n = 1'b1;
              inst_n     = hit_data;
            end else begin
              addr_n   = {pc_in[31:2], 2'b00};
              mc_req_n = 1'b1;
              state_n  = MISS;
            end
          end
        end
        MISS: begin
          if (rdy_inst_mc_in) begin
            fill       = 1'b1;
            inst_n     = inst_mc_in;
            rdy_inst_n = 1'b1;
            mc_req_n   = 1'b0;
            state_n    = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      rdy_inst_out     <= 1'b0;
      inst_out         <= '0;
      rdy_inst_mc_out  <= 1'b0;
      inst_addr_mc_out <= '0;
    end else if (rdy_in) begin
      state            <= state_n;
      rdy_inst_out     <= rdy_inst_n;
      inst_out         <= inst_n;
      rdy_inst_mc_out  <= mc_req_n;
      inst_addr_mc_out <= addr_n;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: random fetch/miss/flush/stall traffic against a transaction-level cache model.
// The model tracks ICACHE_EN the same way the design does (no define: every fetch misses).
module tb_inst_cache;
  localparam int IW = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, fetch_req_in, rdy_inst_mc_in, refresh_rob_cdb_in;
  logic [31:0] pc_in, inst_mc_in;
  logic [31:0] inst_out, inst_addr_mc_out;
  logic        rdy_inst_out, rdy_inst_mc_out;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_inst;
  logic [29:0] mdl_line [int];

  inst_cache #(.INDEX_WIDTH(IW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .fetch_req_in(fetch_req_in), .pc_in(pc_in),
    .inst_out(inst_out), .rdy_inst_out(rdy_inst_out),
    .rdy_inst_mc_out(rdy_inst_mc_out), .inst_addr_mc_out(inst_addr_mc_out),
    .inst_mc_in(inst_mc_in), .rdy_inst_mc_in(rdy_inst_mc_in),
    .refresh_rob_cdb_in(refresh_rob_cdb_in)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] wa;
    wa = {pc[31:2], 2'b00};
    case (wa)
      32'h0000_0100: return 32'h0010_0093;
      32'h0000_0500: return 32'hDEAD_BEEF;
      default:       return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endcase
  endfunction

  function automatic bit mdl_hit(input logic [31:0] pc);
`ifdef ICACHE_EN
    int idx;
    idx = int'((pc >> 2) % (1 << IW));
    return mdl_line.exists(idx) && (mdl_line[idx] == pc[31:2]);
`else
    return (pc === 32'hx);
`endif
  endfunction

  function automatic void mdl_fill(input logic [31:0] pc);
`ifdef ICACHE_EN
    mdl_line[int'((pc >> 2) % (1 << IW))] = pc[31:2];
`else
    mdl_line[0] = pc[31:2];
`endif
  endfunction

  // one complete fetch: lat idle cycles before MemCtrl answers, stall cycles of rdy_in=0 with pulse held
  task automatic do_fetch(input logic [31:0] pc, input int lat, input int stall);
    bit hit;
    hit = mdl_hit(pc);
    fetch_req_in = 1'b1;
    pc_in        = pc;
    tick();
    if (hit) begin
      exp_inst = mem_word(pc);
      chk("hit_rdy",  {31'd0, rdy_inst_out}, 32'd1);
      chk("hit_data", inst_out, exp_inst);
      chk("hit_nomc", {31'd0, rdy_inst_mc_out}, 32'd0);
    end else begin
      chk("miss_req",   {31'd0, rdy_inst_mc_out}, 32'd1);
      chk("miss_addr",  inst_addr_mc_out, {pc[31:2], 2'b00});
      chk("miss_nordy", {31'd0, rdy_inst_out}, 32'd0);
      for (int i = 0; i < lat; i++) begin
        pc_in = $urandom;
        tick();
        chk("hold_req",  {31'd0, rdy_inst_mc_out}, 32'd1);
        chk("hold_addr", inst_addr_mc_out, {pc[31:2], 2'b00});
        chk("hold_nordy", {31'd0, rdy_inst_out}, 32'd0);
      end
      inst_mc_in     = mem_word(pc);
      rdy_inst_mc_in = 1'b1;
      if (stall > 0) begin
        rdy_in = 1'b0;
        for (int i = 0; i < stall; i++) begin
          tick();
          chk("stall_req",   {31'd0, rdy_inst_mc_out}, 32'd1);
          chk("stall_addr",  inst_addr_mc_out, {pc[31:2], 2'b00});
          chk("stall_nordy", {31'd0, rdy_inst_out}, 32'd0);
          chk("stall_inst",  inst_out, exp_inst);
        end
        rdy_in = 1'b1;
      end
      tick();
      rdy_inst_mc_in = 1'b0;
      exp_inst = mem_word(pc);
      chk("fill_rdy",  {31'd0, rdy_inst_out}, 32'd1);
      chk("fill_data", inst_out, exp_inst);
      chk("fill_nomc", {31'd0, rdy_inst_mc_out}, 32'd0);
      mdl_fill(pc);
    end
    // fetcher still holds the request across this edge; it must not be taken again
    pc_in = pc;
    tick();
    fetch_req_in = 1'b0;
    chk("no_reaccept_rdy", {31'd0, rdy_inst_out}, 32'd0);
    chk("no_reaccept_mc",  {31'd0, rdy_inst_mc_out}, 32'd0);
  endtask

  // fetch interrupted by a flush; same_cycle puts the stale MemCtrl pulse on the flush edge
  task automatic flush_fetch(input logic [31:0] pc, input int wait_cyc, input bit same_cycle);
    bit hit;
    hit = mdl_hit(pc);
    fetch_req_in = 1'b1;
    pc_in        = pc;
    if (hit) begin
      refresh_rob_cdb_in = 1'b1;
      tick();
      refresh_rob_cdb_in = 1'b0;
      fetch_req_in       = 1'b0;
      chk("flush_hit_sup", {31'd0, rdy_inst_out}, 32'd0);
      chk("flush_hit_mc",  {31'd0, rdy_inst_mc_out}, 32'd0);
    end else begin
      tick();
      chk("fl_miss_req", {31'd0, rdy_inst_mc_out}, 32'd1);
      for (int i = 0; i < wait_cyc; i++) tick();
      refresh_rob_cdb_in = 1'b1;
      inst_mc_in         = 32'h1234_5678;
      rdy_inst_mc_in     = same_cycle;
      tick();
      refresh_rob_cdb_in = 1'b0;
      fetch_req_in       = 1'b0;
      rdy_inst_mc_in     = ~same_cycle;
      chk("fl_drop_req", {31'd0, rdy_inst_mc_out}, 32'd0);
      chk("fl_nordy",    {31'd0, rdy_inst_out}, 32'd0);
      tick();
      rdy_inst_mc_in = 1'b0;
      chk("fl_late_nordy", {31'd0, rdy_inst_out}, 32'd0);
      chk("fl_late_nomc",  {31'd0, rdy_inst_mc_out}, 32'd0);
      chk("fl_late_inst",  inst_out, exp_inst);
    end
    tick();
    chk("fl_quiet", {31'd0, rdy_inst_out}, 32'd0);
  endtask

  initial begin
    logic [31:0] pool [8];
    pool = '{32'h100, 32'h500, 32'h900, 32'h104, 32'h504, 32'h2000, 32'h3FC, 32'h7FC};
    rst_in = 1'b1; rdy_in = 1'b1; fetch_req_in = 1'b0; pc_in = '0;
    inst_mc_in = '0; rdy_inst_mc_in = 1'b0; refresh_rob_cdb_in = 1'b0;
    exp_inst = '0;
    tick();
    tick();
    chk("rst_rdy",  {31'd0, rdy_inst_out}, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_mc",   {31'd0, rdy_inst_mc_out}, 32'd0);
    chk("rst_addr", inst_addr_mc_out, 32'd0);
    rst_in = 1'b0;

    do_fetch(32'h100, 2, 0);   // cold miss
    do_fetch(32'h100, 0, 0);   // hit when the arrays are built
    do_fetch(32'h500, 1, 0);   // conflicts with 0x100
    do_fetch(32'h100, 0, 0);   // evicted, misses again
    flush_fetch(32'h104, 1, 1'b1);
    flush_fetch(32'h108, 0, 1'b0);
    do_fetch(32'h104, 0, 0);   // flushed miss left no fill
    do_fetch(32'h10C, 1, 3);   // rdy_in low for 3 cycles with pulse held
    flush_fetch(32'h100, 0, 1'b0);
    do_fetch(32'h100, 0, 0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] pc;
      pc = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0)
        flush_fetch(pc, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      else
        do_fetch(pc, $urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped instruction cache between the instruction fetcher and MemCtrl's instruction port. It answers fetch hits from an internal array one cycle after the request. On a miss it acts as the requester on MemCtrl's IC interface: it holds the request and address until MemCtrl's one-cycle response pulse, then fills the line and forwards the word. It abandons an outstanding miss on a ROB refresh.

## Interface
- INDEX_WIDTH, 8, log2 of line count; one 32-bit word per line.
- TAG_WIDTH, 32 - INDEX_WIDTH - 2, tag width; derived, not overridden.
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; when low, all state and outputs hold.
- fetch_req_in  in  1  fetcher request valid; held until `rdy_inst_out`.
- pc_in  in  32  fetch address; bits [1:0] ignored.
- inst_out  out  32  fetched instruction word.
- rdy_inst_out  out  1  one-cycle pulse; `inst_out` valid.
- rdy_inst_mc_out  out  1  request to MemCtrl (its `rdy_inst_ic_in`).
- inst_addr_mc_out  out  32  word address to MemCtrl: {pc[31:2], 2'b00}.
- inst_mc_in  in  32  word returned by MemCtrl.
- rdy_inst_mc_in  in  1  MemCtrl one-cycle response pulse.
- refresh_rob_cdb_in  in  1  pipeline flush.

## Operation
- Storage:
  - data[2^INDEX_WIDTH] x 32.
  - tag[2^INDEX_WIDTH] x TAG_WIDTH.
  - valid vector of 2^INDEX_WIDTH bits.
- Address split: index = pc[INDEX_WIDTH+1:2]; tag = pc[31:INDEX_WIDTH+2].
- Hit = valid[index] && tag[index] == pc tag; evaluated combinationally on `pc_in`.
- States: IDLE, MISS.
- IDLE:
  - Acceptance: `fetch_req_in` is accepted only when `rdy_inst_out` is currently 0. This prevents re-accepting the fetcher's still-held previous request.
  - Hit: next cycle `rdy_inst_out`=1, `inst_out`=data[index]; stay IDLE.
  - Miss: latch pc; next cycle `rdy_inst_mc_out`=1 and `inst_addr_mc_out`=latched word address; go to MISS.
- MISS:
  - Hold `rdy_inst_mc_out`=1 and the address stable every cycle. MemCtrl aborts its transaction if the request drops.
  - Ignore `fetch_req_in` and `pc_in`.
  - On `rdy_inst_mc_in`=1, register all of the following, then go to IDLE:
    - data/tag at the latched index ← `inst_mc_in` / latched tag; valid[index] ← 1.
    - `inst_out` ← `inst_mc_in`; `rdy_inst_out` ← 1.
    - `rdy_inst_mc_out` ← 0.
- `rdy_inst_out` defaults to 0 every enabled cycle unless set as above.
- Flush (`refresh_rob_cdb_in`=1 with `rdy_in`=1):
  - State → IDLE; `rdy_inst_mc_out` ← 0; `rdy_inst_out` ← 0.
  - Array contents and valid bits are kept.
  - A `rdy_inst_mc_in` arriving in the same cycle is discarded: no fill, no forward.
- Priority: rst_in > !rdy_in (hold) > flush > normal operation.

## Timing
- Reset values:
  - state IDLE; valid all 0.
  - `rdy_inst_out`=0, `inst_out`=0.
  - `rdy_inst_mc_out`=0, `inst_addr_mc_out`=0.
  - Data and tag arrays are not reset.
- Hit latency: 1 cycle from request sample to `rdy_inst_out`. Peak throughput: 1 fetch per 2 cycles.
- Miss latency: 1 cycle to raise `rdy_inst_mc_out`, plus MemCtrl latency, plus 1 cycle from `rdy_inst_mc_in` to `rdy_inst_out`.
- `rdy_inst_mc_out` is low in the cycle after the response pulse. MemCtrl is then at stage end-1 and completes or aborts harmlessly; no duplicate fetch is issued.
- MemCtrl's data-port priority only delays the response; the request is held with no timeout.
- Response pulse in the same cycle as `rdy_in`=0: not sampled. MemCtrl also holds while `rdy_in` is low, so the pulse persists.
- Flush on the cycle a hit is accepted: the hit response is suppressed.

## Configuration
- ICACHE_EN defined: cache as described.
- ICACHE_EN undefined: no arrays or valid bits; every request takes the MISS path; no fill.
- Ports and handshake timing are identical in both builds.

## Test plan
- Reset, then request pc=0x0000_0100:
  - `rdy_inst_mc_out`=1 with address 0x100 one cycle later.
  - Respond 0x0010_0093 → next cycle `rdy_inst_out`=1, `inst_out`=0x0010_0093.
- Repeat pc=0x100 after the fill: `rdy_inst_out` one cycle after acceptance; `rdy_inst_mc_out` stays 0.
- Conflict (INDEX_WIDTH=8):
  - Fill 0x100, then fetch 0x500 → miss; fill 0xDEAD_BEEF.
  - Fetch 0x100 again → miss again.
- Flush while MISS:
  - `rdy_inst_mc_out` drops next cycle.
  - A late `rdy_inst_mc_in` with value 0x1234_5678 causes no `rdy_inst_out`.
  - Later fetch of the same pc misses.
- `rdy_in` held low 3 cycles during MISS, with the response pulse held: all outputs frozen; response handled on the first cycle `rdy_in`=1.
- ICACHE_EN undefined: two consecutive fetches of 0x100 each produce a MemCtrl request.
